layer_tile_sequencer: RTL

- Sits directly downstream of the CNN main controller. Consumes its `start_layer` pulse and per-layer configuration, and returns `done_layer`.
- Breaks each layer into systolic tiles: SYSTOLIC_SIZE filters × SYSTOLIC_SIZE input channels per tile.
- For each tile, issues one command to the PE-array/datapath carrying the IFM read base, the OFM write base and the active lane counts.
- OFM RAM uses channel-planar layout: each channel is a contiguous plane of size×size words.

---
 rtl/layer_tile_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/layer_tile_sequencer.sv
// Layer tile sequencer: splits one CNN layer into SYSTOLIC_SIZE x SYSTOLIC_SIZE
// filter/channel tiles and issues one command per tile to the PE-array datapath.
module layer_tile_sequencer #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_RAM_SIZE  = 2378675,
    parameter int ADDR_W        = $clog2(OFM_RAM_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_layer,
    input  logic [8:0]        ifm_size,
    input  logic [10:0]       ifm_channel,
    input  logic [1:0]        kernel_size,
    input  logic [10:0]       num_filter,
    input  logic              maxpool_mode,
    input  logic [1:0]        maxpool_stride,
    input  logic              upsample_mode,
    input  logic [ADDR_W-1:0] start_read_addr,
    input  logic [ADDR_W-1:0] start_write_addr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_read_addr,
    output logic [ADDR_W-1:0] cmd_write_addr,
    output logic [4:0]        cmd_num_ch,
    output logic [4:0]        cmd_num_filter,
    output logic [1:0]        cmd_kernel_size,
    output logic              cmd_first_ch,
    output logic              cmd_last_ch,
    input  logic              tile_done,
    output logic              busy,
    output logic              done_layer
);

    localparam int SHIFT = $clog2(SYSTOLIC_SIZE);
    localparam int GRP_W = 12;
    localparam logic [GRP_W-1:0] GRP_ONE = GRP_W'(1);

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, NEXT, DONE} state_t;

    typedef struct packed {
        logic [8:0]        ifm_size;
        logic [10:0]       ifm_channel;
        logic [1:0]        kernel_size;
        logic [10:0]       num_filter;
        logic              maxpool_mode;
        logic [1:0]        maxpool_stride;
        logic              upsample_mode;
        logic [ADDR_W-1:0] start_read_addr;
        logic [ADDR_W-1:0] start_write_addr;
    } cfg_t;

    state_t            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [ADDR_W-1:0] rstep_q, rstep_d, wstep_q, wstep_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [GRP_W-1:0]  n_cg_q, n_cg_d, n_fg_q, n_fg_d;
    logic [GRP_W-1:0]  cg_q, cg_d, fg_q, fg_d;

    logic [9:0]        osize;
    logic [19:0]       ipl, opl;
    logic [GRP_W-1:0]  n_cg_calc, n_fg_calc;
    logic              last_cg, last_fg, issue;

    // Plane sizes and group counts derived from the shadow copy of the config
    always_comb begin
        if (cfg_q.maxpool_mode && cfg_q.maxpool_stride == 2'd2) begin
            osize = {1'b0, cfg_q.ifm_size} >> 1;
        end else if (cfg_q.upsample_mode) begin
            osize = {cfg_q.ifm_size, 1'b0};
        end else begin
            osize = {1'b0, cfg_q.ifm_size};
        end
        ipl       = 20'(cfg_q.ifm_size) * 20'(cfg_q.ifm_size);
        opl       = 20'(osize) * 20'(osize);
        n_cg_calc = (GRP_W'(cfg_q.ifm_channel) + GRP_W'(SYSTOLIC_SIZE - 1)) >> SHIFT;
        n_fg_calc = (GRP_W'(cfg_q.num_filter) + GRP_W'(SYSTOLIC_SIZE - 1)) >> SHIFT;
        last_cg   = (cg_q == n_cg_q - GRP_ONE);
        last_fg   = (fg_q == n_fg_q - GRP_ONE);
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        rstep_d  = rstep_q;
        wstep_d  = wstep_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        n_cg_d   = n_cg_q;
        n_fg_d   = n_fg_q;
        cg_d     = cg_q;
        fg_d     = fg_q;
        case (state_q)
            IDLE: begin
                if (start_layer) begin
                    cfg_d = '{ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode,
                              maxpool_stride, upsample_mode, start_read_addr, start_write_addr};
                    state_d = SETUP;
                end
            end
            SETUP: begin
                rstep_d  = ADDR_W'(ipl) << SHIFT;
                wstep_d  = ADDR_W'(opl) << SHIFT;
                n_cg_d   = n_cg_calc;
                n_fg_d   = n_fg_calc;
                rd_ptr_d = cfg_q.start_read_addr;
                wr_ptr_d = cfg_q.start_write_addr;
                cg_d     = '0;
                fg_d     = '0;
                state_d  = (n_cg_calc == '0 || n_fg_calc == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) state_d = WAIT;
            end
            WAIT: begin
                if (tile_done) state_d = NEXT;
            end
            NEXT: begin
                // Channel groups form the inner loop; the filter group advances on wrap
                if (!last_cg) begin
                    cg_d     = cg_q + GRP_ONE;
                    rd_ptr_d = rd_ptr_q + rstep_q;
                end else begin
                    cg_d     = '0;
                    rd_ptr_d = cfg_q.start_read_addr;
                    fg_d     = fg_q + GRP_ONE;
                    wr_ptr_d = wr_ptr_q + wstep_q;
                end
                state_d = (last_cg && last_fg) ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            rstep_q  <= '0;
            wstep_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            n_cg_q   <= '0;
            n_fg_q   <= '0;
            cg_q     <= '0;
            fg_q     <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            rstep_q  <= rstep_d;
            wstep_q  <= wstep_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            n_cg_q   <= n_cg_d;
            n_fg_q   <= n_fg_d;
            cg_q     <= cg_d;
            fg_q     <= fg_d;
        end
    end

    // Command fields are only driven while a command is offered, so they read 0 otherwise
    always_comb begin
        issue           = (state_q == ISSUE);
        cmd_valid       = issue;
        cmd_read_addr   = issue ? rd_ptr_q : '0;
        cmd_write_addr  = issue ? wr_ptr_q : '0;
        cmd_num_ch      = '0;
        cmd_num_filter  = '0;
        if (issue) begin
            cmd_num_ch     = last_cg ? 5'(cfg_q.ifm_channel) - 5'(cg_q << SHIFT) : 5'(SYSTOLIC_SIZE);
            cmd_num_filter = last_fg ? 5'(cfg_q.num_filter) - 5'(fg_q << SHIFT) : 5'(SYSTOLIC_SIZE);
        end
        cmd_kernel_size = issue ? cfg_q.kernel_size : '0;
        cmd_first_ch    = issue && (cg_q == '0);
        cmd_last_ch     = issue && last_cg;
        busy            = (state_q != IDLE);
        done_layer      = (state_q == DONE);
    end

endmodule
